// File: rtl/mole_spawner.sv
// mole_spawner: whack-a-mole game core; spawns a pseudo-random mole on one LED and judges switch flips.
// Ports: clk, rst (sync, active-high), pause (freeze game), tick (level tick enable),
//        switch[7:0] (async player switches), led[7:0] (one-hot mole or 0),
//        mole_idx[2:0] (current/last mole), hit/miss (one-cycle score pulses).
// Optional build macro MOLE_SPEEDUP_EN: every 4th consecutive hit shortens the mole lifetime by one tick.
module mole_spawner #(
   parameter int unsigned UP_TICKS  = 3,
   parameter int unsigned GAP_TICKS = 1,
   parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pause,
   input  logic       tick,
   input  logic [7:0] switch,
   output logic [7:0] led,
   output logic [2:0] mole_idx,
   output logic       hit,
   output logic       miss
);
   typedef enum logic [1:0] {GAP, UP, HIT, MISS} state_t;
   state_t     state_q, state_d;
   logic [7:0] sync1_q, sync2_q, prev_q, rise;
   logic [7:0] lfsr_q, lfsr_d, led_q, led_d;
   logic [3:0] cnt_q, cnt_d, life;
   logic [2:0] idx_q, idx_d, n;
   assign rise = sync2_q & ~prev_q;
   // bump the candidate so the same hole never lights twice in a row
   assign n = (lfsr_q[2:0] == idx_q) ? lfsr_q[2:0] + 3'd1 : lfsr_q[2:0];
`ifdef MOLE_SPEEDUP_EN
   logic [1:0] streak_q, streak_d;
   logic [3:0] life_q, life_d;
   always_comb begin
      streak_d = streak_q;
      life_d   = life_q;
      if (!pause && state_q == HIT) begin
         streak_d = streak_q + 2'd1;
         life_d   = (streak_q == 2'd3 && life_q > 4'd1) ? life_q - 4'd1 : life_q;
      end else if (!pause && state_q == MISS) begin
         streak_d = '0;
         life_d   = 4'(UP_TICKS);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         streak_q <= '0;
         life_q   <= 4'(UP_TICKS);
      end else begin
         streak_q <= streak_d;
         life_q   <= life_d;
      end
   end
   assign life = life_q;
`else
   assign life = 4'(UP_TICKS);
`endif
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      led_d   = led_q;
      lfsr_d  = lfsr_q;
      if (!pause) begin
         lfsr_d = lfsr_q[0] ? (lfsr_q >> 1) ^ 8'hB8 : lfsr_q >> 1;
         cnt_d  = cnt_q + {3'd0, tick};
         case (state_q)
            GAP: if (tick && cnt_q == 4'(GAP_TICKS - 1)) begin
               state_d = UP;
               idx_d   = n;
               led_d   = 8'd1 << n;
            end
            UP: begin
               // a correct edge wins over a wrong edge and over expiry
               state_d = rise[idx_q] ? HIT :
                         (|rise || (tick && cnt_q == life - 4'd1)) ? MISS : UP;
               led_d   = (state_d == UP) ? led_q : '0;
            end
            default: state_d = GAP;
         endcase
         cnt_d = (state_d != state_q) ? '0 : cnt_d;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= GAP;
         cnt_q   <= '0;
         idx_q   <= '0;
         led_q   <= '0;
         lfsr_q  <= LFSR_SEED;
         // switches held through reset must not look like fresh flips
         sync1_q <= switch;
         sync2_q <= switch;
         prev_q  <= switch;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         led_q   <= led_d;
         lfsr_q  <= lfsr_d;
         sync1_q <= switch;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end
   assign led      = led_q;
   assign mole_idx = idx_q;
   // pause masks the pulse; the held HIT/MISS state replays it on resume
   assign hit      = state_q == HIT && !pause;
   assign miss     = state_q == MISS && !pause;
endmodule
